wb_nasti_bridge: RTL and testbench
==================================

WB_NASTI_BRIDGE -- requirements
Module: wb_nasti_bridge

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 28, byte-address width on both sides.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, data width on both sides (32 or 64).
REQ-003 SHALL have parameter NASTI_ID_WIDTH, default 4, AXI ID field width.
REQ-004 SHALL have parameter NASTI_ID, default 0, constant ID driven on aw_id/ar_id.
REQ-005 SHALL have one clock and a synchronous, active-high reset: clk in 1 (all logic on rising edge); rst in 1 (synchronous, active-high).
REQ-006 SHALL have ports wb_cyc_i, wb_stb_i, wb_we_i in 1 each; wb_adr_i in ADDR_WIDTH; wb_dat_i in DATA_WIDTH; wb_sel_i in DATA_WIDTH/8; wb_cti_i in 3; wb_bte_i in 2 (Wishbone B3 slave request).
REQ-007 SHALL have ports wb_ack_o, wb_err_o, wb_rty_o out 1 each and wb_dat_o out DATA_WIDTH (Wishbone slave response).
REQ-008 SHALL have AXI write-address ports m_nasti_aw{id,addr,len[8],size[3],burst[2],cache[4],prot[3],qos[4],valid} out and awready in.
REQ-009 SHALL have AXI write-data ports m_nasti_w{data,strb,last,valid} out and wready in.
REQ-010 SHALL have AXI write-response ports m_nasti_b{id,resp[2],valid} in and bready out.
REQ-011 SHALL have AXI read ports: m_nasti_ar* out, mirroring aw*, with arready in; m_nasti_r{id,data,resp[2],last,valid} in and rready out.

Function
REQ-012 SHALL convert each Wishbone beat into exactly one single-beat NASTI transaction: len=0, size=log2(DATA_WIDTH/8), burst=INCR (2'b01), cache/prot/qos=0, wlast=1.
REQ-013 SHALL drive aw_addr/ar_addr as wb_adr_i with the low log2(DATA_WIDTH/8) bits forced to 0; w_strb SHALL equal wb_sel_i; w_data SHALL equal wb_dat_i.
REQ-014 SHALL treat cti/bte as don't-care; every burst beat is handled as an independent single transfer.
REQ-015 SHALL implement the FSM states IDLE, WADDR, WRESP, RADDR, RDATA and RESP.
REQ-016 IDLE SHALL go to WADDR when cyc&stb&we, and to RADDR when cyc&stb&!we; the request fields SHALL be registered on that edge.
REQ-017 WADDR SHALL assert aw_valid and w_valid together from the first cycle.
REQ-018 In WADDR, each valid SHALL deassert independently after its own handshake (valid&ready), and the FSM SHALL go to WRESP once both handshakes are done, including both in the same cycle.
REQ-019 WRESP SHALL hold bready=1 and go to RESP on bvalid, capturing bresp.
REQ-020 RADDR SHALL assert ar_valid and go to RDATA on arready.
REQ-021 RDATA SHALL hold rready=1 and go to RESP on rvalid, capturing rdata into wb_dat_o and capturing rresp.
REQ-022 RESP SHALL last exactly one cycle, pulsing wb_ack_o when the captured resp[1]==0 and wb_err_o otherwise, and SHALL then return to IDLE.
REQ-023 SHALL never assert wb_ack_o and wb_err_o in the same cycle.
REQ-024 wb_rty_o SHALL be constant 0.
REQ-025 Latency with zero-wait NASTI slave: request sampled cycle 0, address/data handshake cycle 1, response cycle 2, ack/err cycle 3.
REQ-026 IDLE SHALL NOT sample a request in the RESP cycle, so a held stb is not issued twice.
REQ-027 If wb_cyc_i drops mid-transaction, the NASTI transaction SHALL run to completion and the RESP cycle SHALL suppress ack/err.
REQ-028 aw_valid, w_valid and ar_valid SHALL stay asserted, with stable payload, until their handshake completes.
REQ-029 wb_dat_o SHALL hold the last read data until the next read response.

Reset
REQ-030 rst SHALL force IDLE and clear all valid/ready outputs, wb_ack_o, wb_err_o and wb_dat_o to 0, with the captured request and response state also cleared.
REQ-031 rst mid-transaction SHALL abandon the transaction; no ack/err SHALL follow the reset.

Verification
REQ-032 Write 0x1000 = 0xDEADBEEF, sel=4'b1111, zero-wait slave -> aw_addr=0x1000, w_strb=F, bready seen, wb_ack_o pulses in cycle 3 only.
REQ-033 Read 0x2004 with slave rdata=0x12345678, rresp=0, arready delayed 4 cycles -> ar_valid held 5 cycles, wb_dat_o=0x12345678 and ack on the cycle after rvalid.
REQ-034 Write with awready in cycle 1 and wready in cycle 3 -> aw_valid drops after cycle 1, w_valid drops after cycle 3, bready asserted from cycle 4.
REQ-035 Read returning rresp=2'b10 -> one wb_err_o pulse, no wb_ack_o.
REQ-036 Incrementing 4-beat WB burst (cti=010) -> 4 separate ar transactions at addresses A, A+4, A+8, A+12 and 4 acks, with no duplicate issue.
REQ-037 cyc dropped while in WRESP -> bvalid still accepted and no ack; rst asserted in RADDR -> ar_valid=0 on the next cycle and no ack afterwards.

Source files
------------

// File: rtl/wb_nasti_bridge.sv
// wb_nasti_bridge: Wishbone B3 slave to single-beat NASTI (AXI4) master bridge
module wb_nasti_bridge #(
  parameter int ADDR_WIDTH     = 28,
  parameter int DATA_WIDTH     = 32,
  parameter int NASTI_ID_WIDTH = 4,
  parameter int NASTI_ID       = 0
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      wb_cyc_i,
  input  logic                      wb_stb_i,
  input  logic                      wb_we_i,
  input  logic [ADDR_WIDTH-1:0]     wb_adr_i,
  input  logic [DATA_WIDTH-1:0]     wb_dat_i,
  input  logic [DATA_WIDTH/8-1:0]   wb_sel_i,
  input  logic [2:0]                wb_cti_i,
  input  logic [1:0]                wb_bte_i,
  output logic                      wb_ack_o,
  output logic                      wb_err_o,
  output logic                      wb_rty_o,
  output logic [DATA_WIDTH-1:0]     wb_dat_o,
  output logic [NASTI_ID_WIDTH-1:0] m_nasti_aw_id,
  output logic [ADDR_WIDTH-1:0]     m_nasti_aw_addr,
  output logic [7:0]                m_nasti_aw_len,
  output logic [2:0]                m_nasti_aw_size,
  output logic [1:0]                m_nasti_aw_burst,
  output logic [3:0]                m_nasti_aw_cache,
  output logic [2:0]                m_nasti_aw_prot,
  output logic [3:0]                m_nasti_aw_qos,
  output logic                      m_nasti_aw_valid,
  input  logic                      m_nasti_aw_ready,
  output logic [DATA_WIDTH-1:0]     m_nasti_w_data,
  output logic [DATA_WIDTH/8-1:0]   m_nasti_w_strb,
  output logic                      m_nasti_w_last,
  output logic                      m_nasti_w_valid,
  input  logic                      m_nasti_w_ready,
  input  logic [NASTI_ID_WIDTH-1:0] m_nasti_b_id,
  input  logic [1:0]                m_nasti_b_resp,
  input  logic                      m_nasti_b_valid,
  output logic                      m_nasti_b_ready,
  output logic [NASTI_ID_WIDTH-1:0] m_nasti_ar_id,
  output logic [ADDR_WIDTH-1:0]     m_nasti_ar_addr,
  output logic [7:0]                m_nasti_ar_len,
  output logic [2:0]                m_nasti_ar_size,
  output logic [1:0]                m_nasti_ar_burst,
  output logic [3:0]                m_nasti_ar_cache,
  output logic [2:0]                m_nasti_ar_prot,
  output logic [3:0]                m_nasti_ar_qos,
  output logic                      m_nasti_ar_valid,
  input  logic                      m_nasti_ar_ready,
  input  logic [NASTI_ID_WIDTH-1:0] m_nasti_r_id,
  input  logic [DATA_WIDTH-1:0]     m_nasti_r_data,
  input  logic [1:0]                m_nasti_r_resp,
  input  logic                      m_nasti_r_last,
  input  logic                      m_nasti_r_valid,
  output logic                      m_nasti_r_ready
);
  localparam int SZ = $clog2(DATA_WIDTH/8);
  typedef enum logic [2:0] {IDLE, WADDR, WRESP, RADDR, RDATA, RESP} state_t;
  state_t state, state_n;
  logic [ADDR_WIDTH-1:0] addr;
  logic [DATA_WIDTH-1:0] data;
  logic [DATA_WIDTH/8-1:0] strb;
  logic aw_done, w_done, err, live;
  logic aw_hs, w_hs;
  logic unused;
  assign unused = ^{m_nasti_b_id, m_nasti_r_id, m_nasti_r_last, wb_cti_i, wb_bte_i,
                    wb_adr_i[SZ-1:0], m_nasti_b_resp[0], m_nasti_r_resp[0]};
  assign aw_hs = m_nasti_aw_valid & m_nasti_aw_ready;
  assign w_hs  = m_nasti_w_valid & m_nasti_w_ready;
  // next-state: one Wishbone beat becomes one complete NASTI transaction
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (wb_cyc_i && wb_stb_i) state_n = wb_we_i ? WADDR : RADDR;
      WADDR:   if ((aw_done || aw_hs) && (w_done || w_hs)) state_n = WRESP;
      WRESP:   if (m_nasti_b_valid) state_n = RESP;
      RADDR:   if (m_nasti_ar_ready) state_n = RDATA;
      RDATA:   if (m_nasti_r_valid) state_n = RESP;
      default: state_n = IDLE;
    endcase
  end
  // state register, request capture in IDLE, handshake tracking and response capture
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      addr     <= '0;
      data     <= '0;
      strb     <= '0;
      aw_done  <= 1'b0;
      w_done   <= 1'b0;
      err      <= 1'b0;
      live     <= 1'b0;
      wb_dat_o <= '0;
    end else begin
      state <= state_n;
      live  <= (state == IDLE) || (live && wb_cyc_i);
      if (state == IDLE) begin
        addr    <= {wb_adr_i[ADDR_WIDTH-1:SZ], {SZ{1'b0}}};
        data    <= wb_dat_i;
        strb    <= wb_sel_i;
        aw_done <= 1'b0;
        w_done  <= 1'b0;
      end
      if (aw_hs) aw_done <= 1'b1;
      if (w_hs) w_done <= 1'b1;
      if (state == WRESP && m_nasti_b_valid) err <= m_nasti_b_resp[1];
      if (state == RDATA && m_nasti_r_valid) begin
        err      <= m_nasti_r_resp[1];
        wb_dat_o <= m_nasti_r_data;
      end
    end
  end
  assign m_nasti_aw_id    = NASTI_ID_WIDTH'(NASTI_ID);
  assign m_nasti_aw_addr  = addr;
  assign m_nasti_aw_len   = 8'd0;
  assign m_nasti_aw_size  = 3'(SZ);
  assign m_nasti_aw_burst = 2'b01;
  assign m_nasti_aw_cache = 4'd0;
  assign m_nasti_aw_prot  = 3'd0;
  assign m_nasti_aw_qos   = 4'd0;
  assign m_nasti_aw_valid = (state == WADDR) && !aw_done;
  assign m_nasti_w_data   = data;
  assign m_nasti_w_strb   = strb;
  assign m_nasti_w_last   = 1'b1;
  assign m_nasti_w_valid  = (state == WADDR) && !w_done;
  assign m_nasti_b_ready  = (state == WRESP);
  assign m_nasti_ar_id    = NASTI_ID_WIDTH'(NASTI_ID);
  assign m_nasti_ar_addr  = addr;
  assign m_nasti_ar_len   = 8'd0;
  assign m_nasti_ar_size  = 3'(SZ);
  assign m_nasti_ar_burst = 2'b01;
  assign m_nasti_ar_cache = 4'd0;
  assign m_nasti_ar_prot  = 3'd0;
  assign m_nasti_ar_qos   = 4'd0;
  assign m_nasti_ar_valid = (state == RADDR);
  assign m_nasti_r_ready  = (state == RDATA);
  assign wb_ack_o = (state == RESP) && live && wb_cyc_i && !err;
  assign wb_err_o = (state == RESP) && live && wb_cyc_i && err;
  assign wb_rty_o = 1'b0;
endmodule

// File: tb/tb_wb_nasti_bridge.sv
// tb_wb_nasti_bridge: scoreboard bench with a programmable NASTI slave model
module tb_wb_nasti_bridge;
  logic clk = 1'b0, rst = 1'b1;
  logic wb_cyc_i = 0, wb_stb_i = 0, wb_we_i = 0;
  logic [27:0] wb_adr_i = '0;
  logic [31:0] wb_dat_i = '0;
  logic [3:0] wb_sel_i = '0;
  logic [2:0] wb_cti_i = '0;
  logic [1:0] wb_bte_i = '0;
  logic wb_ack_o, wb_err_o, wb_rty_o;
  logic [31:0] wb_dat_o;
  logic [3:0] aw_id, ar_id;
  logic [27:0] aw_addr, ar_addr;
  logic [7:0] aw_len, ar_len;
  logic [2:0] aw_size, ar_size, aw_prot, ar_prot;
  logic [1:0] aw_burst, ar_burst;
  logic [3:0] aw_cache, ar_cache, aw_qos, ar_qos;
  logic aw_valid, w_valid, ar_valid, b_ready, r_ready, w_last;
  logic aw_ready = 0, w_ready = 0, ar_ready = 0, b_valid = 0, r_valid = 0, r_last = 1;
  logic [31:0] w_data, r_data = '0;
  logic [3:0] w_strb;
  logic [1:0] b_resp = '0, r_resp = '0;
  logic [3:0] b_id = '0, r_id = '0;

  wb_nasti_bridge dut (
    .clk(clk), .rst(rst),
    .wb_cyc_i(wb_cyc_i), .wb_stb_i(wb_stb_i), .wb_we_i(wb_we_i), .wb_adr_i(wb_adr_i),
    .wb_dat_i(wb_dat_i), .wb_sel_i(wb_sel_i), .wb_cti_i(wb_cti_i), .wb_bte_i(wb_bte_i),
    .wb_ack_o(wb_ack_o), .wb_err_o(wb_err_o), .wb_rty_o(wb_rty_o), .wb_dat_o(wb_dat_o),
    .m_nasti_aw_id(aw_id), .m_nasti_aw_addr(aw_addr), .m_nasti_aw_len(aw_len),
    .m_nasti_aw_size(aw_size), .m_nasti_aw_burst(aw_burst), .m_nasti_aw_cache(aw_cache),
    .m_nasti_aw_prot(aw_prot), .m_nasti_aw_qos(aw_qos), .m_nasti_aw_valid(aw_valid),
    .m_nasti_aw_ready(aw_ready),
    .m_nasti_w_data(w_data), .m_nasti_w_strb(w_strb), .m_nasti_w_last(w_last),
    .m_nasti_w_valid(w_valid), .m_nasti_w_ready(w_ready),
    .m_nasti_b_id(b_id), .m_nasti_b_resp(b_resp), .m_nasti_b_valid(b_valid), .m_nasti_b_ready(b_ready),
    .m_nasti_ar_id(ar_id), .m_nasti_ar_addr(ar_addr), .m_nasti_ar_len(ar_len),
    .m_nasti_ar_size(ar_size), .m_nasti_ar_burst(ar_burst), .m_nasti_ar_cache(ar_cache),
    .m_nasti_ar_prot(ar_prot), .m_nasti_ar_qos(ar_qos), .m_nasti_ar_valid(ar_valid),
    .m_nasti_ar_ready(ar_ready),
    .m_nasti_r_id(r_id), .m_nasti_r_data(r_data), .m_nasti_r_resp(r_resp), .m_nasti_r_last(r_last),
    .m_nasti_r_valid(r_valid), .m_nasti_r_ready(r_ready)
  );

  always #5 clk = ~clk;

  typedef struct {bit err; logic [31:0] data; bit chk_d;} exp_t;
  exp_t exp_q[$];
  logic [27:0] exp_aw[$], exp_ar[$];
  logic [35:0] exp_w[$];
  int checks = 0, failures = 0;
  int aw_dly = 0, w_dly = 0, ar_dly = 0, b_dly = 0, r_dly = 0;
  logic [1:0] bresp_v = 0, rresp_v = 0;
  logic [31:0] rdata_v = 0;
  int aw_cnt = 0, w_cnt = 0, ar_cnt = 0, b_cnt = 0, r_cnt = 0;
  int aw_hold = 0, w_hold = 0, ar_hold = 0, b_hs = 0, ar_hs = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // slave model: readies/valids set at negedge, handshakes land on the next posedge
  initial begin
    forever begin
      @(negedge clk);
      aw_cnt = aw_valid ? aw_cnt + 1 : 0;
      aw_ready = aw_valid && aw_cnt > aw_dly;
      if (aw_ready) begin
        aw_hold = aw_cnt;
        chk("aw_fixed", {aw_id, aw_len, aw_size, aw_burst, aw_cache, aw_prot, aw_qos},
            {4'd0, 8'd0, 3'd2, 2'b01, 4'd0, 3'd0, 4'd0});
        if (exp_aw.size() == 0) chk("aw_extra", 1, 0);
        else chk("aw_addr", aw_addr, exp_aw.pop_front());
      end
      w_cnt = w_valid ? w_cnt + 1 : 0;
      w_ready = w_valid && w_cnt > w_dly;
      if (w_ready) begin
        w_hold = w_cnt;
        chk("w_last", w_last, 1);
        if (exp_w.size() == 0) chk("w_extra", 1, 0);
        else chk("w_strb_data", {w_strb, w_data}, exp_w.pop_front());
      end
      ar_cnt = ar_valid ? ar_cnt + 1 : 0;
      ar_ready = ar_valid && ar_cnt > ar_dly;
      if (ar_ready) begin
        ar_hold = ar_cnt;
        ar_hs++;
        chk("ar_fixed", {ar_id, ar_len, ar_size, ar_burst, ar_cache, ar_prot, ar_qos},
            {4'd0, 8'd0, 3'd2, 2'b01, 4'd0, 3'd0, 4'd0});
        if (exp_ar.size() == 0) chk("ar_extra", 1, 0);
        else chk("ar_addr", ar_addr, exp_ar.pop_front());
      end
      b_cnt = b_ready ? b_cnt + 1 : 0;
      b_valid = b_ready && b_cnt > b_dly;
      b_resp = bresp_v;
      if (b_valid) b_hs++;
      r_cnt = r_ready ? r_cnt + 1 : 0;
      r_valid = r_ready && r_cnt > r_dly;
      r_data = rdata_v;
      r_resp = rresp_v;
    end
  end

  // response monitor: every ack/err pops one expected Wishbone response
  always @(negedge clk) begin
    if (wb_ack_o || wb_err_o) begin
      if (exp_q.size() == 0) chk("wb_resp_unexpected", {wb_ack_o, wb_err_o}, 2'b00);
      else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("wb_resp_kind", {wb_ack_o, wb_err_o}, e.err ? 2'b01 : 2'b10);
        if (e.chk_d) chk("wb_rdata", wb_dat_o, e.data);
      end
    end
  end

  task automatic beat(input bit we, input logic [27:0] a, input logic [31:0] d,
                      input logic [3:0] s, input logic [2:0] cti, input bit hold, output int lat);
    wb_cyc_i = 1; wb_stb_i = 1; wb_we_i = we; wb_adr_i = a; wb_dat_i = d; wb_sel_i = s; wb_cti_i = cti;
    lat = 0;
    do begin @(negedge clk); lat++; end while (!(wb_ack_o || wb_err_o) && lat < 100);
    if (!(wb_ack_o || wb_err_o)) chk("wb_timeout", 0, 1);
    @(posedge clk); #1;
    if (!hold) begin wb_cyc_i = 0; wb_stb_i = 0; wb_we_i = 0; wb_cti_i = 0; end
  endtask

  task automatic wait_sig(input string name, input bit which);
    int n = 0;
    do begin @(negedge clk); n++; end while (!(which ? ar_valid : b_ready) && n < 50);
    if (!(which ? ar_valid : b_ready)) chk(name, 0, 1);
  endtask

  initial begin
    int lat, hs0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_wb", {wb_ack_o, wb_err_o, wb_rty_o, wb_dat_o}, 0);
    chk("rst_nasti", {aw_valid, w_valid, b_ready, ar_valid, r_ready}, 0);
    @(posedge clk); #1 rst = 0;

    exp_aw.push_back(28'h1000); exp_w.push_back({4'hF, 32'hDEADBEEF}); exp_q.push_back('{0, 32'h0, 0});
    beat(1, 28'h1000, 32'hDEADBEEF, 4'hF, 3'b000, 0, lat);
    chk("wr_zero_wait_latency", lat, 4);

    exp_aw.push_back(28'hABCDEF4); exp_w.push_back({4'h5, 32'h5A5AA5A5}); exp_q.push_back('{0, 32'h0, 0});
    beat(1, 28'hABCDEF7, 32'h5A5AA5A5, 4'h5, 3'b000, 0, lat);

    ar_dly = 4; rdata_v = 32'h12345678;
    exp_ar.push_back(28'h2004); exp_q.push_back('{0, 32'h12345678, 1});
    beat(0, 28'h2004, 32'h0, 4'hF, 3'b000, 0, lat);
    chk("rd_arready_delay_latency", lat, 8);
    chk("ar_valid_hold_cycles", ar_hold, 5);
    ar_dly = 0;

    w_dly = 2;
    exp_aw.push_back(28'h3008); exp_w.push_back({4'h3, 32'h0BADF00D}); exp_q.push_back('{0, 32'h0, 0});
    beat(1, 28'h3008, 32'h0BADF00D, 4'h3, 3'b000, 0, lat);
    chk("aw_valid_cycles", aw_hold, 1);
    chk("w_valid_cycles", w_hold, 3);
    chk("wr_split_latency", lat, 6);
    chk("rdata_held_after_write", wb_dat_o, 32'h12345678);
    w_dly = 0;

    rresp_v = 2'b10; rdata_v = 32'hCAFEBABE;
    exp_ar.push_back(28'h4000); exp_q.push_back('{1, 32'h0, 0});
    beat(0, 28'h4000, 32'h0, 4'hF, 3'b000, 0, lat);
    rresp_v = 2'b01; rdata_v = 32'h00C0FFEE;
    exp_ar.push_back(28'h4010); exp_q.push_back('{0, 32'h00C0FFEE, 1});
    beat(0, 28'h4010, 32'h0, 4'hF, 3'b000, 0, lat);
    rresp_v = 2'b00;

    bresp_v = 2'b11;
    exp_aw.push_back(28'h4800); exp_w.push_back({4'h8, 32'h11223344}); exp_q.push_back('{1, 32'h0, 0});
    beat(1, 28'h4800, 32'h11223344, 4'h8, 3'b000, 0, lat);
    bresp_v = 2'b00;

    hs0 = ar_hs;
    for (int i = 0; i < 4; i++) begin
      rdata_v = 32'hA0000000 + 32'(i);
      exp_ar.push_back(28'h5000 + 28'(4 * i)); exp_q.push_back('{0, 32'hA0000000 + 32'(i), 1});
      beat(0, 28'h5000 + 28'(4 * i), 32'h0, 4'hF, i == 3 ? 3'b111 : 3'b010, i != 3, lat);
    end
    repeat (5) @(posedge clk); #1;
    chk("burst_ar_count", ar_hs - hs0, 4);

    b_dly = 3; hs0 = b_hs;
    exp_aw.push_back(28'h6000); exp_w.push_back({4'hF, 32'h77777777});
    wb_cyc_i = 1; wb_stb_i = 1; wb_we_i = 1; wb_adr_i = 28'h6000; wb_dat_i = 32'h77777777; wb_sel_i = 4'hF;
    wait_sig("bready_timeout", 0);
    @(posedge clk); #1 wb_cyc_i = 0; wb_stb_i = 0; wb_we_i = 0;
    repeat (10) @(posedge clk); #1;
    chk("b_accepted_after_cyc_drop", b_hs - hs0, 1);
    b_dly = 0;

    ar_dly = 20; hs0 = ar_hs;
    wb_cyc_i = 1; wb_stb_i = 1; wb_we_i = 0; wb_adr_i = 28'h6800;
    wait_sig("ar_valid_timeout", 1);
    @(posedge clk); #1 rst = 1; wb_cyc_i = 0; wb_stb_i = 0;
    @(posedge clk); #1 rst = 0;
    @(negedge clk);
    chk("ar_valid_after_rst", ar_valid, 0);
    repeat (25) @(posedge clk); #1;
    chk("no_ar_after_rst", ar_hs - hs0, 0);
    ar_dly = 0;

    rdata_v = 32'h0F0F0F0F;
    exp_ar.push_back(28'h7000); exp_q.push_back('{0, 32'h0F0F0F0F, 1});
    beat(0, 28'h7000, 32'h0, 4'hF, 3'b000, 0, lat);
    chk("rd_after_rst_latency", lat, 4);

    repeat (5) @(posedge clk);
    chk("sb_pending", {exp_q.size(), exp_aw.size(), exp_w.size(), exp_ar.size()}, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
